parity_frame_checker: RTL and testbench

- Downstream consumer of the byte-wide parity generator's output stream: receives serial frames of start bit, DATA_W data bits (LSB first), one parity bit and a stop bit.
- Reassembles the data word and checks its parity and framing.
- Presents the word with error flags on a valid/ready output interface to the next block.

---
 rtl/parity_frame_checker.sv | 116 +++++++++++
 tb/tb_parity_frame_checker.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/parity_frame_checker.sv
// Serial frame receiver: start, DATA_W data bits LSB first, parity, stop; checks parity/framing.
// Optional error counter (err_cnt, err_cnt_clr) is enabled with PARITY_FRAME_ERR_CNT_EN.
module parity_frame_checker #(
  parameter int DATA_W     = 8,
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic              par_err,
  output logic              frame_err,
  output logic              overrun
`ifdef PARITY_FRAME_ERR_CNT_EN
  ,
  output logic [15:0]       err_cnt,
  input  logic              err_cnt_clr
`endif
);

  // state  | meaning
  // IDLE   | line idle, waiting for a start bit (sin=0)
  // DATA   | shifting in DATA_W data bits, LSB first
  // PARITY | capturing the parity bit and evaluating the parity check
  // STOP   | sampling the stop bit and committing the frame
  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] DATA   = 2'd1;
  localparam logic [1:0] PARITY = 2'd2;
  localparam logic [1:0] STOP   = 2'd3;

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic [1:0]        state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W:0]   shift_cat;
  logic              par_pend;
  logic              commit;
  logic              accept;

  // Right shift with sin entering at the MSB, so the first data bit ends in bit 0.
  assign shift_cat = {sin, sreg};
  assign commit    = bit_en && (state == STOP);
  assign accept    = dout_valid && dout_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      sreg     <= '0;
      par_pend <= 1'b0;
    end else if (bit_en) begin
      case (state)
        IDLE: begin
          if (!sin) begin
            state   <= DATA;
            bit_cnt <= '0;
          end
        end
        DATA: begin
          sreg <= shift_cat[DATA_W:1];
          if (bit_cnt == LAST_BIT) begin
            state <= PARITY;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
        PARITY: begin
          par_pend <= (^sreg) ^ sin ^ ODD_PARITY;
          state    <= STOP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // A commit always wins over the handshake; the held frame is then either
  // accepted this cycle (no overrun) or overwritten (overrun).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      par_err    <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else if (commit) begin
      dout       <= sreg;
      par_err    <= par_pend;
      frame_err  <= ~sin;
      dout_valid <= 1'b1;
      overrun    <= dout_valid && !dout_ready;
    end else if (accept) begin
      dout_valid <= 1'b0;
      overrun    <= 1'b0;
    end
  end

`ifdef PARITY_FRAME_ERR_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt <= '0;
    end else if (err_cnt_clr) begin
      err_cnt <= '0;
    end else if (commit && (par_pend || !sin) && (err_cnt != 16'hFFFF)) begin
      err_cnt <= err_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_parity_frame_checker.sv
// Directed bench for parity_frame_checker (DATA_W=8, even parity).
// Also covers the error counter when PARITY_FRAME_ERR_CNT_EN is defined.
module tb_parity_frame_checker;

  logic       clk;
  logic       rst;
  logic       bit_en;
  logic       sin;
  logic [7:0] dout;
  logic       dout_valid;
  logic       dout_ready;
  logic       par_err;
  logic       frame_err;
  logic       overrun;
`ifdef PARITY_FRAME_ERR_CNT_EN
  logic [15:0] err_cnt;
  logic        err_cnt_clr;
`endif

  int checks = 0;
  int errors = 0;

  parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1'b0)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .sin        (sin),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .par_err    (par_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
`ifdef PARITY_FRAME_ERR_CNT_EN
    ,
    .err_cnt    (err_cnt),
    .err_cnt_clr(err_cnt_clr)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Non-strobe cycles carry the inverted bit so ignored samples would corrupt the frame.
  task automatic drive_bit(input logic b, input int period);
    for (int i = 1; i < period; i++) begin
      @(negedge clk);
      bit_en = 1'b0;
      sin    = ~b;
    end
    @(negedge clk);
    bit_en = 1'b1;
    sin    = b;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input int period);
    drive_bit(1'b0, period);
    for (int i = 0; i < 8; i++) drive_bit(d[i], period);
    drive_bit(par, period);
    drive_bit(stop, period);
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] d, input logic v,
                           input logic pe, input logic fe, input logic ov);
    check_val({tag, "_dout"},  {8'h00, dout}, {8'h00, d});
    check_val({tag, "_valid"}, {15'h0, dout_valid}, {15'h0, v});
    check_val({tag, "_par"},   {15'h0, par_err}, {15'h0, pe});
    check_val({tag, "_frame"}, {15'h0, frame_err}, {15'h0, fe});
    check_val({tag, "_ovr"},   {15'h0, overrun}, {15'h0, ov});
  endtask

  initial begin
    rst        = 1'b1;
    bit_en     = 1'b0;
    sin        = 1'b1;
    dout_ready = 1'b1;
`ifdef PARITY_FRAME_ERR_CNT_EN
    err_cnt_clr = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_out("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check_val("reset_cnt", err_cnt, 16'd0);
`endif
    rst = 1'b0;
    idle_cycle();

    // Clean A5 at full rate; valid must be a single-cycle pulse with ready high.
    send_frame(8'hA5, 1'b0, 1'b1, 1);
    idle_cycle();
    check_out("a5", 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycle();
    check_out("a5_after", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0);

    // 07 has odd weight; sending parity 0 is a parity error.
    send_frame(8'h07, 1'b0, 1'b1, 1);
    idle_cycle();
    check_out("07", 8'h07, 1'b1, 1'b1, 1'b0, 1'b0);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check_val("cnt_07", err_cnt, 16'd1);
`endif

    send_frame(8'h3C, 1'b0, 1'b0, 1);
    idle_cycle();
    check_out("3c", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check_val("cnt_3c", err_cnt, 16'd2);
    err_cnt_clr = 1'b1;
    idle_cycle();
    err_cnt_clr = 1'b0;
    idle_cycle();
    check_val("cnt_clr", err_cnt, 16'd0);
`endif

    // Back-to-back frames with no consumer: second overwrites the first.
    dout_ready = 1'b0;
    send_frame(8'h11, 1'b0, 1'b1, 1);
    send_frame(8'h22, 1'b0, 1'b1, 1);
    idle_cycle();
    check_out("ovr", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    idle_cycle();
    check_out("ovr_hold", 8'h22, 1'b1, 1'b0, 1'b0, 1'b1);
    dout_ready = 1'b1;
    idle_cycle();
    check_out("ovr_acc", 8'h22, 1'b0, 1'b0, 1'b0, 1'b0);

    // Strobe every 4th cycle.
    send_frame(8'hF0, 1'b0, 1'b1, 4);
    idle_cycle();
    check_out("f0_slow", 8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle_cycle();

    // Reset after three data bits of a partial frame.
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1);
    drive_bit(1'b0, 1);
    drive_bit(1'b1, 1);
    @(negedge clk);
    rst    = 1'b1;
    bit_en = 1'b0;
    sin    = 1'b1;
    @(negedge clk);
    check_out("mid_rst", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      bit_en = 1'b1;
      sin    = 1'b1;
    end
    idle_cycle();
    check_val("no_partial", {15'h0, dout_valid}, 16'h0000);
    send_frame(8'h5A, 1'b0, 1'b1, 1);
    idle_cycle();
    check_out("5a", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
`ifdef PARITY_FRAME_ERR_CNT_EN
    check_val("cnt_5a", err_cnt, 16'd0);
`endif

    repeat (2) idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
